// File: rtl/memr_seq_pkg.sv
// memr_seq_pkg
// Shared definitions for the memR stream sequencer:
//   - default geometry of memR (element width, address width, elements per word)
//   - derived data/address widths DATA_W and AW
//   - sequencer state encoding
//   - saturating increment helper used by the optional stall counter
//     (present only when MEMR_SEQ_PERF_CNT_EN is defined)
package memr_seq_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int ADDRESS_WIDTH = 20;
    localparam int NO_OF_UNITS   = 8;
    localparam int DATA_W        = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int AW            = ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/memr_seq_addr_gen.sv
// memr_seq_addr_gen
// One side (read or write) of the sequencer's address walk: holds the base
// address, counts issued words, and keeps a registered address equal to
// base + count, wrapping modulo 2^address_width.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   load   in   capture base, clear count (accepted start)
//   base   in   first address of the walk
//   len    in   number of words in the walk (held stable by the caller)
//   step   in   one word issued this cycle; advance count and address
//   addr   out  registered base + count
//   more   out  count < len
//   last   out  count + 1 == len (the word being issued now is the final one)
module memr_seq_addr_gen
    import memr_seq_pkg::*;
#(
    parameter int address_width = AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [address_width-1:0] base,
    input  logic [address_width-1:0] len,
    input  logic                     step,
    output logic [address_width-1:0] addr,
    output logic                     more,
    output logic                     last
);

    localparam logic [address_width-1:0] ONE_AW  = {{(address_width-1){1'b0}}, 1'b1};
    localparam logic [address_width-1:0] ZERO_AW = {address_width{1'b0}};

    logic [address_width-1:0] base_r;
    logic [address_width-1:0] cnt_r;
    logic [address_width-1:0] addr_r;
    logic [address_width-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_r + ONE_AW;

    // Base capture, word counter and wrapping address register.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r <= ZERO_AW;
            cnt_r  <= ZERO_AW;
            addr_r <= ZERO_AW;
        end else if (load) begin
            base_r <= base;
            cnt_r  <= ZERO_AW;
            addr_r <= base;
        end else if (step) begin
            cnt_r  <= cnt_inc_s;
            // Truncation to address_width gives the silent wrap past all-ones.
            addr_r <= base_r + cnt_inc_s;
        end
    end

    assign addr = addr_r;
    assign more = (cnt_r < len);
    // cnt_r < len whenever step can be high, so cnt_inc_s cannot overflow here.
    assign last = (cnt_inc_s == len);

endmodule

// File: rtl/memr_stream_sequencer.sv
// memr_stream_sequencer
// Runs one pass over memR: streams words rd_base..rd_base+length-1 from the
// asynchronous read port to the datapath (out_valid/out_ready) and writes the
// datapath's returned words to wr_base..wr_base+length-1 through the
// synchronous write port (in_valid/in_ready). Completion is keyed on the
// write side only.
// Optional feature: define MEMR_SEQ_PERF_CNT_EN to add the stall_cycles
// output (RUN cycles lost to out-side or in-side backpressure, saturating).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       one-cycle request, honoured only in IDLE
//   rd_base, wr_base, length    pass parameters captured on accepted start
//   busy                        high in RUN and DONE
//   finish                      high for the single DONE cycle
//   mem_read_address, mem_rdata memR read port (data combinational from address)
//   mem_write_enable/_address   memR write port controls
//   mem_wdata                   memR write data (= in_data)
//   out_valid/out_ready/out_data  read stream to the datapath
//   in_valid/in_ready/in_data     result stream from the datapath
//   stall_cycles                only with MEMR_SEQ_PERF_CNT_EN
module memr_stream_sequencer
    import memr_seq_pkg::*;
#(
    parameter int element_width = ELEMENT_WIDTH,
    parameter int address_width = ADDRESS_WIDTH,
    parameter int no_of_units   = NO_OF_UNITS,
    localparam int data_w       = no_of_units * element_width
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [address_width-1:0] rd_base,
    input  logic [address_width-1:0] wr_base,
    input  logic [address_width-1:0] length,
    output logic                     busy,
    output logic                     finish,
    output logic [address_width-1:0] mem_read_address,
    input  logic [data_w-1:0]        mem_rdata,
    output logic                     mem_write_enable,
    output logic [address_width-1:0] mem_write_address,
    output logic [data_w-1:0]        mem_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [data_w-1:0]        out_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [data_w-1:0]        in_data
`ifdef MEMR_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam logic [address_width-1:0] ZERO_AW = {address_width{1'b0}};

    seq_state_e               state_r;
    seq_state_e               state_nx_s;
    logic [address_width-1:0] length_r;
    logic                     busy_r;
    logic                     finish_r;
    logic                     out_valid_r;
    logic [data_w-1:0]        out_data_r;

    logic                     start_acc_s;
    logic                     rd_load_s;
    logic                     rd_more_s;
    logic                     rd_last_unused_s;
    logic                     in_ready_s;
    logic                     wr_hs_s;
    logic                     wr_more_s;
    logic                     wr_last_s;
    logic [address_width-1:0] rd_addr_s;
    logic [address_width-1:0] wr_addr_s;

    assign start_acc_s = (state_r == IDLE) & start;
    assign rd_load_s   = (state_r == RUN) & rd_more_s & (~out_valid_r | out_ready);
    // Reset gates the write port combinationally so no beat lands in a reset cycle.
    assign in_ready_s  = (state_r == RUN) & wr_more_s & ~reset;
    assign wr_hs_s     = in_valid & in_ready_s;

    memr_seq_addr_gen #(
        .address_width (address_width)
    ) u_rd_gen (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc_s),
        .base  (rd_base),
        .len   (length_r),
        .step  (rd_load_s),
        .addr  (rd_addr_s),
        .more  (rd_more_s),
        .last  (rd_last_unused_s)
    );

    memr_seq_addr_gen #(
        .address_width (address_width)
    ) u_wr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc_s),
        .base  (wr_base),
        .len   (length_r),
        .step  (wr_hs_s),
        .addr  (wr_addr_s),
        .more  (wr_more_s),
        .last  (wr_last_s)
    );

    // Next-state logic: a zero-length pass goes straight to DONE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length == ZERO_AW) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = RUN;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (wr_hs_s && wr_last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register with busy/finish registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            length_r <= ZERO_AW;
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != IDLE);
            finish_r <= (state_nx_s == DONE);
            if (start_acc_s) begin
                length_r <= length;
            end
        end
    end

    // Read-stream output register; a word left unconsumed at DONE is dropped on return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {data_w{1'b0}};
        end else begin
            if (state_r == DONE) begin
                out_valid_r <= 1'b0;
            end else if (rd_load_s) begin
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (rd_load_s) begin
                out_data_r <= mem_rdata;
            end
        end
    end

`ifdef MEMR_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles_r;

    // Stall counter: cleared on accepted start, counts RUN cycles with backpressure on either side.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_cycles_r <= 32'd0;
        end else if ((state_r == RUN) &&
                     ((out_valid_r && !out_ready) || (in_ready_s && !in_valid))) begin
            stall_cycles_r <= sat_inc32(stall_cycles_r);
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    // Without the performance option there is no stall counter and no extra port.
`endif

    assign busy              = busy_r;
    assign finish            = finish_r;
    assign mem_read_address  = rd_addr_s;
    assign mem_write_address = wr_addr_s;
    assign mem_write_enable  = wr_hs_s;
    assign mem_wdata         = in_data;
    assign out_valid         = out_valid_r;
    assign out_data          = out_data_r;
    assign in_ready          = in_ready_s;

endmodule

// File: tb/tb_memr_stream_sequencer.sv
// tb_memr_stream_sequencer
// Directed bench for memr_stream_sequencer. memR is modelled as a fixed
// pattern on the read side (word = {8{12'hA5C, address}}) and a write log on
// the write side. An optional echo model returns each consumed out word to
// in_data two cycles later.
module tb_memr_stream_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [19:0]  rd_base, wr_base, length;
    logic         busy, finish;
    logic [19:0]  mem_read_address, mem_write_address;
    logic [255:0] mem_rdata, mem_wdata;
    logic         mem_write_enable;
    logic         out_valid, out_ready;
    logic [255:0] out_data;
    logic         in_valid, in_ready;
    logic [255:0] in_data;
`ifdef MEMR_SEQ_PERF_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    always #5 clk = ~clk;

    memr_stream_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .rd_base           (rd_base),
        .wr_base           (wr_base),
        .length            (length),
        .busy              (busy),
        .finish            (finish),
        .mem_read_address  (mem_read_address),
        .mem_rdata         (mem_rdata),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_wdata         (mem_wdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data)
`ifdef MEMR_SEQ_PERF_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    function automatic logic [255:0] pat(input logic [19:0] a);
        return {8{12'hA5C, a}};
    endfunction

    assign mem_rdata = pat(mem_read_address);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records handshakes just before the edge that completes them.
    logic [255:0] out_q[$];
    logic [19:0]  wa_q[$];
    logic [255:0] wd_q[$];
    int           wr_count  = 0;
    int           fin_count = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid_held", out_valid, 1'b1);
            chk("stall_data_held", out_data, prev_data);
        end
        prev_stall = out_valid & ~out_ready & ~reset & ~finish;
        prev_data  = out_data;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (mem_write_enable) begin
            wa_q.push_back(mem_write_address);
            wd_q.push_back(mem_wdata);
            wr_count++;
        end
        if (finish) fin_count++;
    end

    // Echo datapath: out handshake in cycle c appears on in_valid in cycle c+2.
    logic         echo_en = 1'b0;
    logic         pv0 = 1'b0, pv1 = 1'b0;
    logic [255:0] pd0 = '0, pd1 = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (echo_en) begin
            in_valid = pv1;
            in_data  = pd1;
            pv1 = pv0;
            pd1 = pd0;
            pv0 = out_valid & out_ready;
            pd0 = out_data;
        end
    endtask

    task automatic wait_finish(input int maxc, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            tick();
            if (finish) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_finish_seen"}, seen, 1'b1);
    endtask

    task automatic clear_logs();
        out_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [19:0] wrap_tab [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    logic [3:0]  rpat = 4'b1001;
    int w0, f0;

    initial begin
        reset = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0; length = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        // ---- reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 256'd0);
        chk("rst_rd_addr", mem_read_address, 20'd0);
        chk("rst_wr_addr", mem_write_address, 20'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        tick();

        // ---- 1: basic pass, length 4, echo with 2-cycle lag
        clear_logs(); w0 = wr_count; f0 = fin_count;
        rd_base = 20'h00010; wr_base = 20'h00040; length = 20'd4;
        out_ready = 1'b1; echo_en = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy", busy, 1'b1);
        chk("t1_no_valid_yet", out_valid, 1'b0);
        chk("t1_rd_addr0", mem_read_address, 20'h00010);
        chk("t1_wr_addr0", mem_write_address, 20'h00040);
        chk("t1_in_ready", in_ready, 1'b1);
        tick();
        chk("t1_first_valid", out_valid, 1'b1);
        chk("t1_first_data", out_data, pat(20'h00010));
        wait_finish(30, "t1");
        tick();
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_finish_after", finish, 1'b0);
        chk("t1_finish_pulses", fin_count - f0, 1);
        chk("t1_nreads", out_q.size(), 4);
        chk("t1_nwrites", wr_count - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rd_word", out_q[i], pat(20'h00010 + 20'(i)));
            chk("t1_wr_addr", wa_q[i], 20'h00040 + 20'(i));
            chk("t1_wr_data", wd_q[i], pat(20'h00010 + 20'(i)));
        end

        // ---- 2: zero length
        echo_en = 1'b0; in_valid = 1'b0;
        clear_logs(); w0 = wr_count;
        length = 20'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t2_busy", busy, 1'b1);
        chk("t2_finish", finish, 1'b1);
        chk("t2_out_valid", out_valid, 1'b0);
        chk("t2_in_ready", in_ready, 1'b0);
        tick();
        chk("t2_busy_after", busy, 1'b0);
        chk("t2_finish_after", finish, 1'b0);
        chk("t2_no_writes", wr_count - w0, 0);
        chk("t2_no_reads", out_q.size(), 0);

        // ---- 3: out_ready toggled 1,0,0,1 over length 8
        clear_logs(); w0 = wr_count;
        pv0 = 1'b0; pv1 = 1'b0; echo_en = 1'b1;
        rd_base = 20'h00100; wr_base = 20'h00200; length = 20'd8;
        out_ready = 1'b1; start = 1'b1;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 80; k++) begin
                tick(); start = 1'b0;
                out_ready = rpat[k % 4];
                if (finish) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t3_finish_seen", seen, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_nreads", out_q.size(), 8);
        chk("t3_nwrites", wr_count - w0, 8);
        chk("t3_rd_addr_end", mem_read_address, 20'h00108);
        for (int i = 0; i < 8; i++) begin
            chk("t3_rd_word", out_q[i], pat(20'h00100 + 20'(i)));
            chk("t3_wr_addr", wa_q[i], 20'h00200 + 20'(i));
        end

        // ---- 4: address wrap
        clear_logs();
        rd_base = 20'hFFFFE; wr_base = 20'hFFFFE; length = 20'd4; start = 1'b1;
        tick(); start = 1'b0;
        wait_finish(30, "t4");
        tick();
        chk("t4_nreads", out_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t4_rd_word", out_q[i], pat(wrap_tab[i]));
            chk("t4_wr_addr", wa_q[i], wrap_tab[i]);
        end

        // ---- 5: reset mid-run, then clean restart with an ignored start
        clear_logs(); w0 = wr_count;
        rd_base = 20'h00300; wr_base = 20'h00380; length = 20'd6; start = 1'b1;
        tick(); start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (wr_count - w0 >= 2) break;
        end
        chk("t5_two_writes", wr_count - w0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0; echo_en = 1'b0; in_valid = 1'b0;
        pv0 = 1'b0; pv1 = 1'b0;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_finish", finish, 1'b0);
        chk("t5_rst_in_ready", in_ready, 1'b0);
        chk("t5_rst_rd_addr", mem_read_address, 20'd0);
        chk("t5_rst_wr_addr", mem_write_address, 20'd0);
        chk("t5_rst_out_data", out_data, 256'd0);
        chk("t5_no_write_in_reset", wr_count - w0, 2);
        repeat (3) tick();
        clear_logs(); w0 = wr_count;
        rd_base = 20'h00500; wr_base = 20'h00580; length = 20'd3;
        echo_en = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        rd_base = 20'h7AAAA; wr_base = 20'h7BBBB; length = 20'd9; start = 1'b1;
        tick(); start = 1'b0;
        chk("t5_still_busy", busy, 1'b1);
        wait_finish(30, "t5");
        tick();
        chk("t5_busy_after", busy, 1'b0);
        chk("t5_nreads", out_q.size(), 3);
        chk("t5_nwrites", wr_count - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_rd_word", out_q[i], pat(20'h00500 + 20'(i)));
            chk("t5_wr_addr", wa_q[i], 20'h00580 + 20'(i));
        end

        // ---- 7: DONE reached with an unconsumed read word
        echo_en = 1'b0;
        clear_logs(); w0 = wr_count;
        rd_base = 20'h00600; wr_base = 20'h00680; length = 20'd2;
        out_ready = 1'b0; in_valid = 1'b1; in_data = pat(20'h00999); start = 1'b1;
        tick(); start = 1'b0;
        chk("t7_valid0", out_valid, 1'b0);
        tick();
        chk("t7_valid1", out_valid, 1'b1);
        chk("t7_data1", out_data, pat(20'h00600));
        tick();
        chk("t7_finish", finish, 1'b1);
        chk("t7_valid_in_done", out_valid, 1'b1);
        tick();
        chk("t7_valid_cleared", out_valid, 1'b0);
        chk("t7_busy_after", busy, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t7_nwrites", wr_count - w0, 2);
        chk("t7_wr_addr1", wa_q[1], 20'h00681);
        chk("t7_wr_data0", wd_q[0], pat(20'h00999));

`ifdef MEMR_SEQ_PERF_CNT_EN
        // ---- 6: stall counter, out_ready low for 5 RUN cycles
        rd_base = 20'h00700; wr_base = 20'h00780; length = 20'd8;
        out_ready = 1'b1; in_valid = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("t6_cleared", stall_cycles, 32'd0);
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        wait_finish(20, "t6");
        chk("t6_stalls", stall_cycles, 32'd5);
        in_valid = 1'b0;
        tick(); tick();
        chk("t6_stalls_held", stall_cycles, 32'd5);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
